// File: rtl/jpeg_huff_pkg.sv
// Shared definitions for the JPEG Huffman decode path.
// Contents: default widths, block size, amplitude category limit,
// EOB/ZRL run-size codes, controller state type and token classifiers.
package jpeg_huff_pkg;

    localparam int unsigned COEF_W_DEF  = 8;
    localparam int unsigned DC_W_DEF    = 12;
    localparam int unsigned AMP_W_DEF   = 11;
    localparam int unsigned BLK_N       = 64;
    localparam int unsigned AMP_CAT_MAX = 11;

    localparam logic [3:0] EOB_RUN  = 4'd0;
    localparam logic [3:0] EOB_SIZE = 4'd0;
    localparam logic [3:0] ZRL_RUN  = 4'd15;
    localparam logic [3:0] ZRL_SIZE = 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_DC   = 3'd2,
        ST_AC   = 3'd3,
        ST_OUT  = 3'd4
    } dec_state_t;

    function automatic logic is_eob(input logic [3:0] run, input logic [3:0] size);
        return (run == EOB_RUN) && (size == EOB_SIZE);
    endfunction

    function automatic logic is_zrl(input logic [3:0] run, input logic [3:0] size);
        return (run == ZRL_RUN) && (size == ZRL_SIZE);
    endfunction

endpackage

// File: rtl/huffman_amp_decode.sv
// Combinational JPEG amplitude decoder.
// Ports:
//   i_size     category (0..15); values above the category limit flag an error
//   i_bits     raw amplitude bits, right-aligned; bits at or above i_size ignored
//   o_amp      signed amplitude (0 for size 0 or an illegal size)
//   o_size_err i_size exceeds the category limit
module huffman_amp_decode
    import jpeg_huff_pkg::*;
#(
    parameter int unsigned AMP_W = AMP_W_DEF
) (
    input  logic [3:0]         i_size,
    input  logic [AMP_W-1:0]   i_bits,
    output logic signed [AMP_W:0] o_amp,
    output logic               o_size_err
);

    logic [AMP_W:0] w_mask;
    logic [AMP_W:0] w_mag;
    logic [AMP_W:0] w_msb;

    always_comb begin
        o_size_err = (i_size > 4'(AMP_CAT_MAX));
        // w_mask = 2^size - 1; its top set bit is the sign-selecting bit
        w_mask = ~({(AMP_W+1){1'b1}} << i_size);
        w_mag  = {1'b0, i_bits} & w_mask;
        w_msb  = w_mask ^ (w_mask >> 1);
        o_amp  = '0;
        if (!o_size_err) begin
            // leading 0 marks a negative value: b - (2^size - 1); size 0 yields 0
            if ((w_mag & w_msb) != '0) o_amp = signed'(w_mag);
            else                       o_amp = signed'(w_mag - w_mask);
        end
    end

endmodule

// File: rtl/huffman_dec_controller.sv
// JPEG Huffman decode controller: turns (run,size,bits) tokens into one
// 8x8 zigzag-ordered coefficient block with DC prediction and clipping.
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   dec_start          new scan: clears predictor/errors, aborts current block
//   tok_valid/ready    token handshake; tok_run, tok_size, tok_bits payload
//   block_valid/ready  block handshake; zigzag_pix_out holds coefficient k
//                      at [COEF_W*k +: COEF_W]
//   blk_sat            a coefficient of the current block was saturated
//   err_overrun        sticky: AC run went past index 63
//   err_size           sticky: illegal token size seen
module huffman_dec_controller
    import jpeg_huff_pkg::*;
#(
    parameter int unsigned COEF_W = COEF_W_DEF,
    parameter int unsigned DC_W   = DC_W_DEF,
    parameter int unsigned AMP_W  = AMP_W_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      dec_start,
    input  logic                      tok_valid,
    output logic                      tok_ready,
    input  logic [3:0]                tok_run,
    input  logic [3:0]                tok_size,
    input  logic [AMP_W-1:0]          tok_bits,
    output logic                      block_valid,
    input  logic                      block_ready,
    output logic [BLK_N*COEF_W-1:0]   zigzag_pix_out,
    output logic                      blk_sat,
    output logic                      err_overrun,
    output logic                      err_size
);

    localparam int unsigned CW = (DC_W > AMP_W + 1) ? DC_W : AMP_W + 1;
    localparam logic signed [CW-1:0] C_MAX = CW'((2 ** (COEF_W - 1)) - 1);
    localparam logic signed [CW-1:0] C_MIN = ~C_MAX;

    dec_state_t                  r_state;
    logic [6:0]                  r_pos;
    logic signed [DC_W-1:0]      r_pred;
    logic [BLK_N*COEF_W-1:0]     r_matrix;
    logic                        r_blk_sat;
    logic                        r_err_overrun;
    logic                        r_err_size;

    logic signed [AMP_W:0]       w_amp;
    logic                        w_size_err;
    logic                        w_accept;
    logic                        w_is_eob;
    logic                        w_is_zrl;
    logic [6:0]                  w_tgt;
    logic [6:0]                  w_next;
    logic                        w_overrun;
    logic signed [DC_W-1:0]      w_dc_sum;
    logic [COEF_W:0]             w_dc_clip;
    logic [COEF_W:0]             w_ac_clip;

    // {saturated, value}
    function automatic logic [COEF_W:0] clip_coef(input logic signed [CW-1:0] v);
        logic [COEF_W:0] res;
        if (v > C_MAX)      res = {1'b1, C_MAX[COEF_W-1:0]};
        else if (v < C_MIN) res = {1'b1, C_MIN[COEF_W-1:0]};
        else                res = {1'b0, v[COEF_W-1:0]};
        return res;
    endfunction

    huffman_amp_decode #(.AMP_W(AMP_W)) u_amp (
        .i_size     (tok_size),
        .i_bits     (tok_bits),
        .o_amp      (w_amp),
        .o_size_err (w_size_err)
    );

    assign tok_ready = !reset && !dec_start && ((r_state == ST_DC) || (r_state == ST_AC));
    assign w_accept  = tok_valid && tok_ready;
    assign w_is_eob  = is_eob(tok_run, tok_size);
    assign w_is_zrl  = is_zrl(tok_run, tok_size);

    // ZRL behaves like run=15 with no write: its last zero lands on pos+15,
    // so the same overrun test and advance cover both token kinds.
    assign w_tgt     = r_pos + {3'b000, tok_run};
    assign w_next    = w_tgt + 7'd1;
    assign w_overrun = (w_tgt > 7'(BLK_N - 1));

    // predictor wraps at DC_W; only the emitted coefficient is clipped
    assign w_dc_sum  = r_pred + DC_W'(w_amp);
    assign w_dc_clip = clip_coef(CW'(w_dc_sum));
    assign w_ac_clip = clip_coef(CW'(w_amp));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pos         <= '0;
            r_pred        <= '0;
            r_matrix      <= '0;
            r_blk_sat     <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_size    <= 1'b0;
        end else if (dec_start) begin
            r_state       <= ST_CLR;
            r_pred        <= '0;
            r_err_overrun <= 1'b0;
            r_err_size    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_IDLE;
                ST_CLR: begin
                    r_matrix  <= '0;
                    r_pos     <= 7'd1;
                    r_blk_sat <= 1'b0;
                    r_state   <= ST_DC;
                end
                ST_DC: begin
                    if (w_accept) begin
                        r_pred                <= w_dc_sum;
                        r_matrix[COEF_W-1:0]  <= w_dc_clip[COEF_W-1:0];
                        r_blk_sat             <= r_blk_sat | w_dc_clip[COEF_W];
                        r_err_size            <= r_err_size | w_size_err;
                        r_state               <= ST_AC;
                    end
                end
                ST_AC: begin
                    if (w_accept) begin
                        r_err_size <= r_err_size | w_size_err;
                        if (w_is_eob) begin
                            r_state <= ST_OUT;
                        end else if (w_overrun) begin
                            r_err_overrun <= 1'b1;
                            r_state       <= ST_OUT;
                        end else begin
                            if (!w_is_zrl) begin
                                r_matrix[COEF_W*w_tgt[5:0] +: COEF_W] <= w_ac_clip[COEF_W-1:0];
                                r_blk_sat <= r_blk_sat | w_ac_clip[COEF_W];
                            end
                            r_pos <= w_next;
                            if (w_next == 7'(BLK_N)) r_state <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (block_ready) r_state <= ST_CLR;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign block_valid    = (r_state == ST_OUT);
    assign zigzag_pix_out = r_matrix;
    assign blk_sat        = r_blk_sat;
    assign err_overrun    = r_err_overrun;
    assign err_size       = r_err_size;

endmodule
